// File: rtl/win_pkg.sv
// win_pkg: shared defaults, state encoding and counter-width helpers
// for the streaming 3x3 window generator.
package win_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 415;
  localparam int IMG_H_DEF = 738;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  localparam int COL_W_DEF = cnt_w(IMG_W_DEF);
  localparam int ROW_W_DEF = cnt_w(IMG_H_DEF + 2);
endpackage

// File: rtl/line_buf.sv
// line_buf: one image row of storage. Read and write share one circular pointer,
// so the word read is the pixel written exactly DEPTH advances earlier.
module line_buf import win_pkg::*; #(
  parameter int DEPTH = IMG_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);
  localparam int AW = cnt_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  assign ptr_d = !en_i ? ptr_q : (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
  assign dout_o = mem_q[ptr_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  always_ff @(posedge clk)
    if (en_i) mem_q[ptr_q] <= din_i;
endmodule

// File: rtl/win3x3_stream_gen.sv
// win3x3_stream_gen: raster pixel stream in, clamp-to-edge 3x3 neighbourhood out,
// one window per pixel position, trailing the input by IMG_W+1 pixels.
module win3x3_stream_gen import win_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PIX_W-1:0]         in_pixel_i,
  output logic                     out_valid_o,
  output logic [PIX_W-1:0]         p00_o,
  output logic [PIX_W-1:0]         p01_o,
  output logic [PIX_W-1:0]         p02_o,
  output logic [PIX_W-1:0]         p10_o,
  output logic [PIX_W-1:0]         p11_o,
  output logic [PIX_W-1:0]         p12_o,
  output logic [PIX_W-1:0]         p20_o,
  output logic [PIX_W-1:0]         p21_o,
  output logic [PIX_W-1:0]         p22_o,
  output logic [$clog2(IMG_H)-1:0] out_row_o,
  output logic [$clog2(IMG_W)-1:0] out_col_o,
  output logic                     frame_done_o
);
  localparam int RW = cnt_w(IMG_H + 2);
  localparam int CW = $clog2(IMG_W);
  localparam int OW = $clog2(IMG_H);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FL = RW'(IMG_H);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  typedef logic [2:0][PIX_W-1:0] col_t;
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d, out_col_q, out_col_d;
  logic [OW-1:0] out_row_q, out_row_d;
  col_t prev_q, prev_d, cur_q, cur_d, col_n, lft, rgt;
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic out_valid_q, out_valid_d, done_q, done_d;
  logic acc, step, wrap, last, emit, lb_en;
  logic [PIX_W-1:0] a_rd, b_rd;
  // row_q/col_q address the pixel being consumed; rows IMG_H and IMG_H+1 are the
  // virtual flush rows that drain the last IMG_W+1 windows.
  assign in_ready_o = state_q != FLUSH;
  assign acc = in_valid_i && in_ready_o;
  assign step = acc || state_q == FLUSH;
  assign wrap = col_q == '0;
  assign last = row_q == ROW_END;
  assign emit = step && (wrap ? row_q >= RW'(2) : row_q != '0);
  assign lb_en = step && !last;
  // Column entering the window: rows r-2, r-1, r with top/bottom clamping.
  assign col_n = {row_q == ROW_FL ? a_rd : in_pixel_i, a_rd, row_q == RW'(1) ? a_rd : b_rd};
  line_buf #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb_cur (
    .clk, .rst_n, .en_i(lb_en), .din_i(in_pixel_i), .dout_o(a_rd)
  );
  line_buf #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb_prev (
    .clk, .rst_n, .en_i(lb_en), .din_i(a_rd), .dout_o(b_rd)
  );
  // On a row wrap the finishing window is the previous row's right edge, so the
  // right column replicates the centre instead of taking the new row's pixel.
  always_comb begin
    lft = (wrap || col_q != CW'(1)) ? prev_q : cur_q;
    rgt = wrap ? cur_q : col_n;
    win_d = win_q;
    for (int x = 0; x < 3; x++) if (emit) win_d[x] = {rgt[x], cur_q[x], lft[x]};
    prev_d = step ? cur_q : prev_q;
    cur_d = step ? col_n : cur_q;
    col_d = !step ? col_q : (last || col_q == COL_LAST) ? '0 : col_q + CW'(1);
    row_d = !step ? row_q : last ? '0 : (col_q == COL_LAST) ? row_q + RW'(1) : row_q;
    out_valid_d = emit;
    done_d = emit && last;
    out_row_d = emit ? OW'(wrap ? row_q - RW'(2) : row_q - RW'(1)) : out_row_q;
    out_col_d = emit ? (wrap ? COL_LAST : col_q - CW'(1)) : out_col_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = acc ? FILL : IDLE;
      FILL:    state_d = (acc && row_q == RW'(1) && wrap) ? RUN : FILL;
      RUN:     state_d = (acc && row_q == ROW_LAST && col_q == COL_LAST) ? FLUSH : RUN;
      FLUSH:   state_d = last ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      prev_q <= '0;
      cur_q <= '0;
      win_q <= '0;
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      prev_q <= prev_d;
      cur_q <= cur_d;
      win_q <= win_d;
      out_valid_q <= out_valid_d;
      done_q <= done_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  assign out_valid_o = out_valid_q;
  assign frame_done_o = done_q;
  assign out_row_o = out_row_q;
  assign out_col_o = out_col_q;
  assign p00_o = win_q[0][0];
  assign p01_o = win_q[0][1];
  assign p02_o = win_q[0][2];
  assign p10_o = win_q[1][0];
  assign p11_o = win_q[1][1];
  assign p12_o = win_q[1][2];
  assign p20_o = win_q[2][0];
  assign p21_o = win_q[2][1];
  assign p22_o = win_q[2][2];
endmodule

// File: tb/tb_win3x3_stream_gen.sv
// tb_win3x3_stream_gen: 4x3 image (pixel = base + 4r + c) streamed through the window
// generator; windows, timing, handshake and frame totals checked against a clamp model.
module tb_win3x3_stream_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam logic [71:0] HAND_00 = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5};
  localparam logic [71:0] HAND_11 = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
  localparam logic [71:0] HAND_13 = {8'd2, 8'd3, 8'd3, 8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11};
  localparam logic [71:0] HAND_23 = {8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11, 8'd10, 8'd11, 8'd11};
  localparam logic [71:0] HAND_B00 = {8'd100, 8'd100, 8'd101, 8'd100, 8'd100, 8'd101, 8'd104, 8'd104, 8'd105};
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, frame_done;
  logic [7:0] in_pixel, p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic [1:0] out_row, out_col;
  logic [71:0] win;
  int n_chk = 0, n_pass = 0;
  int kcnt = 0, fl = 0, j = 0, win_cnt = 0, fbase = 0;
  logic pend = 1'b0, exp_ready, macc;
  win3x3_stream_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pixel_i(in_pixel), .out_valid_o(out_valid),
    .p00_o(p00), .p01_o(p01), .p02_o(p02), .p10_o(p10), .p11_o(p11), .p12_o(p12),
    .p20_o(p20), .p21_o(p21), .p22_o(p22),
    .out_row_o(out_row), .out_col_o(out_col), .frame_done_o(frame_done)
  );
  assign win = {p00, p01, p02, p10, p11, p12, p20, p21, p22};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction
  function automatic logic [71:0] model(input int b, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++)
        w[71 - 8 * (3 * x + y) -: 8] = 8'(b + 4 * clampi(r - 1 + x, H - 1) + clampi(c - 1 + y, W - 1));
    return w;
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, "_win"}, win, '0);
    chk({tag, "_valid"}, 72'(out_valid), 72'(0));
    chk({tag, "_done"}, 72'(frame_done), 72'(0));
    chk({tag, "_ready"}, 72'(in_ready), 72'(1));
    chk({tag, "_rowcol"}, 72'({out_row, out_col}), 72'(0));
  endtask
  task automatic send(input int base, input int idle_pct, input int n);
    int k, guard;
    logic acc;
    k = 0;
    guard = 0;
    while (k < n && guard < 1000) begin
      in_valid = ($urandom_range(0, 99) >= idle_pct);
      in_pixel = 8'(base + k);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    chk("sent", 72'(k), 72'(n));
  endtask
  // Reference model of handshake and output timing, evaluated between clock edges.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        kcnt = 0;
        fl = 0;
        pend = 1'b0;
        j = 0;
        win_cnt = 0;
      end else begin
        exp_ready = kcnt != W * H;
        chk("ready", 72'(in_ready), 72'(exp_ready));
        chk("valid", 72'(out_valid), 72'(pend));
        if (out_valid && pend) begin
          chk("row", 72'(out_row), 72'(j / W));
          chk("col", 72'(out_col), 72'(j % W));
          chk("win", win, model(fbase, j / W, j % W));
          chk("done", 72'(frame_done), 72'(j == W * H - 1));
          if (fbase == 0 && j == 0) chk("hand_w00", win, HAND_00);
          if (fbase == 0 && j == 5) chk("hand_w11", win, HAND_11);
          if (fbase == 0 && j == 7) chk("hand_w13", win, HAND_13);
          if (fbase == 0 && j == 11) chk("hand_w23", win, HAND_23);
          if (fbase == 100 && j == 0) chk("hand_b_w00", win, HAND_B00);
          j = (j == W * H - 1) ? 0 : j + 1;
          win_cnt++;
        end else chk("done_idle", 72'(frame_done), 72'(0));
        if (!exp_ready) begin
          pend = 1'b1;
          fl++;
          if (fl == W + 1) begin
            kcnt = 0;
            fl = 0;
          end
        end else begin
          macc = in_valid && exp_ready;
          pend = macc && kcnt >= W + 1;
          if (macc) begin
            if (kcnt == 0) fbase = int'(in_pixel);
            kcnt++;
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    in_valid = 1'b0;
    in_pixel = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("t1");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 0, W * H);
    repeat (8) @(posedge clk);
    #1 chk("t4_count", 72'(win_cnt), 72'(12));
    send(0, 40, W * H);
    repeat (8) @(posedge clk);
    #1 chk("t5_count", 72'(win_cnt), 72'(24));
    send(0, 0, 8);
    #2 rst_n = 1'b0;
    #1 check_reset("t6_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 0, W * H);
    send(100, 0, W * H);
    repeat (8) @(posedge clk);
    #1 chk("t6_count", 72'(win_cnt), 72'(24));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/win3x3_stream_gen.md
Name: win3x3_stream_gen

Overview:
- Streaming 3x3 window generator.
- Accepts grayscale pixels in raster order, one per cycle, and buffers two image rows internally.
- Emits, for every pixel position, the full 3x3 neighbourhood with border replication (clamp-to-edge).
- Sits directly upstream of Edge_detection and drives its p00..p22 inputs, so the Sobel stage can run on a live pixel stream instead of a memory-addressed frame.

Parameters:
- IMG_W, 415, pixels per row (>= 2)
- IMG_H, 738, rows per frame (>= 2)
- PIX_W, 8, bits per pixel

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- in_valid  in  1  in_pixel valid this cycle.
- in_ready  out  1  Block can accept a pixel; transfer when in_valid && in_ready.
- in_pixel  in  PIX_W  Raster-order pixel, row 0 col 0 first.
- out_valid  out  1  Window outputs valid this cycle (single-cycle pulse per window).
- p00,p01,p02,p10,p11,p12,p20,p21,p22  out  PIX_W each  Window; pXY = img[clampR(R-1+X)][clampC(C-1+Y)].
- out_row  out  clog2(IMG_H)  Centre row R of the current window.
- out_col  out  clog2(IMG_W)  Centre column C of the current window.
- frame_done  out  1  Pulses together with the last window (R=IMG_H-1, C=IMG_W-1).

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, frame_done=0, all p*=0, out_row=0, out_col=0, in_ready=1.
  - Counters and state cleared; line-buffer contents are don't-care.
  - Reset mid-frame abandons the frame; the next accepted pixel is (0,0) of a new frame.
- Clamp rules:
  - clampR(x) = 0 if x<0; IMG_H-1 if x>IMG_H-1; else x.
  - clampC is the same rule using IMG_W-1.
- Index definitions:
  - k = input raster index, 0..IMG_W*IMG_H-1.
  - j = output raster index, j = R*IMG_W + C.
- Output timing:
  - Window j is registered and presented the cycle after input k = j+IMG_W+1 is accepted.
  - The first window, (0,0), appears one cycle after pixel (1,1) is accepted.
- Lead phase (FILL): the first IMG_W+1 accepted pixels produce no output.
- RUN:
  - Each accepted pixel produces exactly one window on the next cycle.
  - When in_valid=0, out_valid=0 on the next cycle and output fields hold their values.
- FLUSH:
  - Entered after the last input pixel is accepted.
  - in_ready=0 for exactly IMG_W+1 cycles.
  - One window is emitted per cycle regardless of in_valid; this emits windows j = IMG_W*IMG_H-IMG_W-1 .. IMG_W*IMG_H-1.
  - frame_done=1 on the final window only.
- State machine IDLE -> FILL -> RUN -> FLUSH -> IDLE:
  - IDLE to FILL on the first accept.
  - FILL to RUN after accept k=IMG_W.
  - RUN to FLUSH after accept k=IMG_W*IMG_H-1.
  - FLUSH to IDLE after the final window.
  - in_ready=1 in IDLE, FILL and RUN.
- Back-to-back frames: in_ready returns to 1 on the cycle after the final window; the next accept starts a new frame with no state carried over.
- Frame totals: exactly IMG_W*IMG_H out_valid pulses per frame, in strict raster order; out_row/out_col match j.
- Border handling is applied only at true image borders.
  - Top and bottom rows replicate row 0 / row IMG_H-1.
  - Column replication never mixes pixels from adjacent rows (column wrap is forbidden).
- Storage:
  - Two line buffers of depth IMG_W, each one read and one write per cycle.
  - A 3x3 register array with column shift.
  - No combinational path from in_* to out_*.

Decomposition:
- Package win_pkg:
  - PIX_W default.
  - Default IMG_W/IMG_H for the 415x738 image.
  - State enum {IDLE, FILL, RUN, FLUSH}.
  - Counter-width helper localparams.
- One sub-module, line_buf:
  - Parameterised depth IMG_W x PIX_W.
  - Circular buffer with rd/wr pointer wrap at IMG_W.
  - Instantiated twice, for row R-1 and row R.

Test Plan (IMG_W=4, IMG_H=3; image pixel = 4r+c, fed k=0..11 unless stated):
- T1 reset: hold rst_n=0 -> out_valid=0, frame_done=0, p*=0, in_ready=1. Assert rst_n asynchronously mid-clock -> outputs clear immediately.
- T2 first window (continuous stream): no out_valid before accept k=5. Cycle after k=5 -> out_valid=1, (R,C)=(0,0), p00=0 p01=0 p02=1 p10=0 p11=0 p12=1 p20=4 p21=4 p22=5.
- T3 interior and right edge:
  - Window (1,1) -> 0,1,2 / 4,5,6 / 8,9,10.
  - Window (1,3) -> 2,3,3 / 6,7,7 / 10,11,11.
- T4 flush and corner:
  - After k=11: in_ready=0 for 5 cycles with 5 windows.
  - Last window (2,3) -> 6,7,7 / 10,11,11 / 10,11,11, with frame_done=1.
  - Total out_valid count = 12.
- T5 gaps: random in_valid de-assertion (>=30% idle) -> identical window sequence to T2-T4; out_valid never asserted on the cycle after a non-accept in FILL/RUN.
- T6 reset mid-frame then back-to-back frames:
  - Reset after k=7, then two full frames with the second frame = 100+pixel.
  - 24 windows total.
  - Second frame's (0,0) window = 100,100,101 / 100,100,101 / 104,104,105.
  - No window mixes frames.
